ptp_reg_wr_arb: RTL and testbench
=================================

PTP_REG_WR_ARB -- requirements
Module: ptp_reg_wr_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: register data width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8: byte-strobe width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255: downstream ack timeout, valid range 1..65535.
REQ-005 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, synchronous active-high reset).
REQ-006 SHALL have, for n in {0,1}, inputs reg_wr_addr_n (ADDR_WIDTH), reg_wr_data_n (DATA_WIDTH), reg_wr_strb_n (STRB_WIDTH), reg_wr_en_n (1) and reg_wr_lock_n (1): upstream write requests; port 0 is host CSR, port 1 is time_sync.
REQ-007 SHALL have, for n in {0,1}, outputs reg_wr_wait_n (1) and reg_wr_ack_n (1): upstream handshake.
REQ-008 SHALL have outputs m_reg_wr_addr, m_reg_wr_data, m_reg_wr_strb and m_reg_wr_en, plus inputs m_reg_wr_wait and m_reg_wr_ack: a single downstream port to the PTP clock register write interface.
REQ-009 SHALL have output timeout_err (1): one-cycle pulse on a forced completion.

Function
REQ-010 Handshake: requester holds en and addr/data/strb stable until its one-cycle ack; the downstream port obeys the same rule; m_reg_wr_wait is informational only.
REQ-011 FSM states SHALL be IDLE, BUSY and HOLD.
REQ-012 IDLE: on any en_n, SHALL register the grant and capture addr/data/strb; m_reg_wr_en rises the next cycle; go to BUSY.
REQ-013 Round-robin: if both request in IDLE, SHALL grant the port not served last; last_grant resets to 1, so port 0 wins first.
REQ-014 BUSY: on m_reg_wr_ack, SHALL drop m_reg_wr_en and pulse reg_wr_ack_g for exactly one cycle, both on the next edge (ack latency 1 cycle).
REQ-015 After that ack, SHALL go to HOLD if reg_wr_lock_g was high at m_reg_wr_ack, else to IDLE with last_grant = g.
REQ-016 HOLD: SHALL service only port g; a new en_g re-enters BUSY as in REQ-012; lock_g low with en_g low returns to IDLE.
REQ-017 HOLD: other-port requests SHALL wait; minimum gap between downstream writes is 1 idle cycle.
REQ-018 reg_wr_wait_n SHALL be high while en_n is high and its ack is not being issued, including while not granted.
REQ-019 If en_g drops in BUSY (protocol violation), SHALL keep m_reg_wr_en until m_reg_wr_ack, suppress reg_wr_ack_g, then go to IDLE.
REQ-020 m_reg_wr_addr/data/strb SHALL be registered and held constant while m_reg_wr_en is high.

Reset
REQ-021 On rst, SHALL set: state IDLE, m_reg_wr_en 0, m_reg_wr_addr/data/strb 0, reg_wr_ack_n 0, timeout_err 0, last_grant 1, timeout counter 0.
REQ-022 Reset mid-transaction SHALL drop m_reg_wr_en at the next edge without issuing any upstream ack; requesters still holding en are re-arbitrated after reset.
REQ-023 reg_wr_wait_n follows REQ-018 during reset.

Configuration
REQ-024 Macro PTP_REG_WR_ARB_TIMEOUT_EN defined: a 16-bit counter SHALL count BUSY cycles without m_reg_wr_ack.
REQ-025 With the macro, on reaching TIMEOUT_CYCLES the block SHALL drop m_reg_wr_en, ack the granted requester, pulse timeout_err, go to IDLE and clear any lock; the counter clears on entering BUSY.
REQ-026 Macro undefined: BUSY SHALL wait indefinitely, timeout_err is tied 0 and no counter is synthesized.

Verification
REQ-027 Single write: en_0, addr 0x0210, data 0x12345678, downstream ack 3 cycles after m_reg_wr_en -> m_reg_wr_en high cycle 1, ack_0 one cycle after m_ack, m_addr/data match.
REQ-028 Simultaneous en_0 and en_1 from reset, three writes each -> grants alternate 0,1,0,1,0,1, no ack lost or duplicated.
REQ-029 Port 1 three writes (ToD ns, sec_l, sec_h) with lock_1 high while port 0 requests -> port 1's three writes are back-to-back on downstream, then port 0 is granted.
REQ-030 rst asserted 2 cycles into BUSY -> m_reg_wr_en 0 next cycle, no ack_n; after release, held request is re-granted and completed.
REQ-031 With PTP_REG_WR_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, downstream never acks -> ack_0 and timeout_err pulse after 8 BUSY cycles, arbiter returns to IDLE; without macro, request stays pending.

Source files
------------

// File: rtl/ptp_reg_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : ptp_reg_wr_arb
// Purpose  : Two-port round-robin arbiter with lock for the PTP clock register
//            write interface. Optional macro PTP_REG_WR_ARB_TIMEOUT_EN adds a
//            downstream ack timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ptp_reg_wr_arb #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] reg_wr_addr_0,
    input  logic [DATA_WIDTH-1:0] reg_wr_data_0,
    input  logic [STRB_WIDTH-1:0] reg_wr_strb_0,
    input  logic                  reg_wr_en_0,
    input  logic                  reg_wr_lock_0,
    output logic                  reg_wr_wait_0,
    output logic                  reg_wr_ack_0,

    input  logic [ADDR_WIDTH-1:0] reg_wr_addr_1,
    input  logic [DATA_WIDTH-1:0] reg_wr_data_1,
    input  logic [STRB_WIDTH-1:0] reg_wr_strb_1,
    input  logic                  reg_wr_en_1,
    input  logic                  reg_wr_lock_1,
    output logic                  reg_wr_wait_1,
    output logic                  reg_wr_ack_1,

    output logic [ADDR_WIDTH-1:0] m_reg_wr_addr,
    output logic [DATA_WIDTH-1:0] m_reg_wr_data,
    output logic [STRB_WIDTH-1:0] m_reg_wr_strb,
    output logic                  m_reg_wr_en,
    input  logic                  m_reg_wr_wait,
    input  logic                  m_reg_wr_ack,

    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;
    logic   grant;
    logic   last_grant;
    logic   viol;
    logic   tmo_hit;

    logic                  req_0;
    logic                  req_1;
    logic                  pick;
    logic                  g_en;
    logic                  g_lock;
    logic                  g_req;
    logic                  g_ok;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_data;
    logic [STRB_WIDTH-1:0] cap_strb;

    // A requester still sees en high during its ack cycle; masking it there
    // prevents a duplicate grant of the write that was just completed.
    assign req_0 = reg_wr_en_0 & ~reg_wr_ack_0;
    assign req_1 = reg_wr_en_1 & ~reg_wr_ack_1;

    assign reg_wr_wait_0 = req_0;
    assign reg_wr_wait_1 = req_1;

    wire unused_m_wait = m_reg_wr_wait;

    always_comb begin
        pick = grant;
        if (state == IDLE) begin
            pick = (req_0 && req_1) ? ~last_grant : req_1;
        end
        g_en     = grant ? reg_wr_en_1   : reg_wr_en_0;
        g_lock   = grant ? reg_wr_lock_1 : reg_wr_lock_0;
        g_req    = grant ? req_1         : req_0;
        g_ok     = g_en & ~viol;
        cap_addr = pick ? reg_wr_addr_1 : reg_wr_addr_0;
        cap_data = pick ? reg_wr_data_1 : reg_wr_data_0;
        cap_strb = pick ? reg_wr_strb_1 : reg_wr_strb_0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            viol          <= 1'b0;
            m_reg_wr_en   <= 1'b0;
            m_reg_wr_addr <= '0;
            m_reg_wr_data <= '0;
            m_reg_wr_strb <= '0;
            reg_wr_ack_0  <= 1'b0;
            reg_wr_ack_1  <= 1'b0;
        end else begin
            reg_wr_ack_0 <= 1'b0;
            reg_wr_ack_1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_0 || req_1) begin
                        grant         <= pick;
                        m_reg_wr_addr <= cap_addr;
                        m_reg_wr_data <= cap_data;
                        m_reg_wr_strb <= cap_strb;
                        m_reg_wr_en   <= 1'b1;
                        viol          <= 1'b0;
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    if (m_reg_wr_ack || tmo_hit) begin
                        m_reg_wr_en  <= 1'b0;
                        last_grant   <= grant;
                        reg_wr_ack_0 <= g_ok & ~grant;
                        reg_wr_ack_1 <= g_ok & grant;
                        // A timeout never enters HOLD, which clears any lock.
                        state <= (m_reg_wr_ack && g_ok && g_lock) ? HOLD : IDLE;
                    end else if (!g_en) begin
                        viol <= 1'b1;
                    end
                end
                HOLD: begin
                    if (g_req) begin
                        m_reg_wr_addr <= cap_addr;
                        m_reg_wr_data <= cap_data;
                        m_reg_wr_strb <= cap_strb;
                        m_reg_wr_en   <= 1'b1;
                        viol          <= 1'b0;
                        state         <= BUSY;
                    end else if (!g_lock && !g_en) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PTP_REG_WR_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;

    assign tmo_hit = (state == BUSY) && !m_reg_wr_ack && (tmo_cnt == TMO_LAST);

    // Held at zero outside BUSY, so every new downstream write starts from 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_hit;
            if (state != BUSY || tmo_hit) begin
                tmo_cnt <= '0;
            end else if (!m_reg_wr_ack) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ptp_reg_wr_arb.sv
`default_nettype none
// Testbench for ptp_reg_wr_arb: directed requester sequences, expected
// downstream writes and upstream acks are queued and checked by monitors.
module tb_ptp_reg_wr_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] reg_wr_addr_0 = '0, reg_wr_addr_1 = '0;
    logic [31:0] reg_wr_data_0 = '0, reg_wr_data_1 = '0;
    logic [3:0]  reg_wr_strb_0 = '0, reg_wr_strb_1 = '0;
    logic        reg_wr_en_0 = 1'b0, reg_wr_en_1 = 1'b0;
    logic        reg_wr_lock_0 = 1'b0, reg_wr_lock_1 = 1'b0;
    logic        reg_wr_wait_0, reg_wr_wait_1, reg_wr_ack_0, reg_wr_ack_1;
    logic [15:0] m_reg_wr_addr;
    logic [31:0] m_reg_wr_data;
    logic [3:0]  m_reg_wr_strb;
    logic        m_reg_wr_en;
    logic        m_reg_wr_ack = 1'b0;
    logic        timeout_err;

    ptp_reg_wr_arb #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .STRB_WIDTH(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .reg_wr_addr_0(reg_wr_addr_0), .reg_wr_data_0(reg_wr_data_0),
        .reg_wr_strb_0(reg_wr_strb_0), .reg_wr_en_0(reg_wr_en_0),
        .reg_wr_lock_0(reg_wr_lock_0), .reg_wr_wait_0(reg_wr_wait_0),
        .reg_wr_ack_0(reg_wr_ack_0),
        .reg_wr_addr_1(reg_wr_addr_1), .reg_wr_data_1(reg_wr_data_1),
        .reg_wr_strb_1(reg_wr_strb_1), .reg_wr_en_1(reg_wr_en_1),
        .reg_wr_lock_1(reg_wr_lock_1), .reg_wr_wait_1(reg_wr_wait_1),
        .reg_wr_ack_1(reg_wr_ack_1),
        .m_reg_wr_addr(m_reg_wr_addr), .m_reg_wr_data(m_reg_wr_data),
        .m_reg_wr_strb(m_reg_wr_strb), .m_reg_wr_en(m_reg_wr_en),
        .m_reg_wr_wait(1'b0), .m_reg_wr_ack(m_reg_wr_ack),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_ack[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  men_rise_cyc = -1;
    int  last_ack_cyc = -1;
    int  tmo_seen = 0;
    int  tmo_cyc = -1;
    int  ds_delay = 1;
    bit  ds_enable = 1'b1;
    int  ds_cnt = 0;
    wr_t cur;
    logic men_prev = 1'b0, ack0_prev = 1'b0, ack1_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream slave: acks ds_delay cycles after m_reg_wr_en rises.
    initial forever begin
        @(posedge clk);
        #1;
        if (m_reg_wr_ack) begin
            m_reg_wr_ack = 1'b0;
            ds_cnt = 0;
        end else if (!m_reg_wr_en) begin
            ds_cnt = 0;
        end else begin
            ds_cnt++;
            if (ds_enable && ds_cnt >= ds_delay + 1) m_reg_wr_ack = 1'b1;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (m_reg_wr_en && !men_prev) begin
            men_rise_cyc = cyc;
            if (exp_wr.size() == 0) begin
                chk("unexpected_m_wr", 1, 0);
            end else begin
                cur = exp_wr.pop_front();
                chk("m_addr", m_reg_wr_addr, cur.a);
                chk("m_data", m_reg_wr_data, cur.d);
                chk("m_strb", m_reg_wr_strb, cur.s);
            end
        end else if (m_reg_wr_en) begin
            chk("m_hold_stable", {m_reg_wr_addr, m_reg_wr_data, m_reg_wr_strb}, cur);
        end
        if (reg_wr_ack_0 || reg_wr_ack_1) begin
            last_ack_cyc = cyc;
            chk("ack_both", reg_wr_ack_0 & reg_wr_ack_1, 0);
            chk("ack_width", (reg_wr_ack_0 & ack0_prev) | (reg_wr_ack_1 & ack1_prev), 0);
            chk("wait_in_ack", reg_wr_ack_1 ? reg_wr_wait_1 : reg_wr_wait_0, 0);
            if (exp_ack.size() == 0) chk("unexpected_ack", 1, 0);
            else chk("ack_port", reg_wr_ack_1, exp_ack.pop_front());
        end
        if (timeout_err) begin
            tmo_seen++;
            tmo_cyc = cyc;
        end
        men_prev  = m_reg_wr_en;
        ack0_prev = reg_wr_ack_0;
        ack1_prev = reg_wr_ack_1;
    end

    // Requester model; entered just after a rising edge.
    task automatic wr(input int p, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic lk);
        bit got = 1'b0;
        if (p == 0) begin
            reg_wr_addr_0 = a; reg_wr_data_0 = d; reg_wr_strb_0 = s;
            reg_wr_lock_0 = lk; reg_wr_en_0 = 1'b1;
        end else begin
            reg_wr_addr_1 = a; reg_wr_data_1 = d; reg_wr_strb_1 = s;
            reg_wr_lock_1 = lk; reg_wr_en_1 = 1'b1;
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((p == 0) ? reg_wr_ack_0 : reg_wr_ack_1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk($sformatf("ack_timeout_p%0d", p), 0, 1);
        @(posedge clk);
        #1;
        if (p == 0) begin reg_wr_en_0 = 1'b0; reg_wr_lock_0 = 1'b0; end
        else        begin reg_wr_en_1 = 1'b0; reg_wr_lock_1 = 1'b0; end
    endtask

    task automatic wait_men(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_reg_wr_en) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("men_wait_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
    endtask

    initial begin
        int t0;
        bit ok;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        chk("rst_m_en", m_reg_wr_en, 0);
        chk("rst_m_addr", m_reg_wr_addr, 0);
        chk("rst_m_data", m_reg_wr_data, 0);
        chk("rst_m_strb", m_reg_wr_strb, 0);
        chk("rst_acks", {reg_wr_ack_0, reg_wr_ack_1}, 0);
        chk("rst_waits", {reg_wr_wait_0, reg_wr_wait_1}, 0);
        chk("rst_tmo", timeout_err, 0);

        // Single write, downstream ack 3 cycles after m_reg_wr_en.
        ds_delay = 3;
        exp_wr.push_back('{16'h0210, 32'h12345678, 4'hF});
        exp_ack.push_back(0);
        @(posedge clk); #1;
        t0 = cyc;
        wr(0, 16'h0210, 32'h12345678, 4'hF, 1'b0);
        chk("single_men_latency", men_rise_cyc - t0, 1);
        chk("single_ack_latency", last_ack_cyc - t0, 5);

        // Simultaneous requests from reset: grants alternate starting at 0.
        do_reset();
        ds_delay = 1;
        for (int i = 0; i < 3; i++) begin
            exp_wr.push_back('{16'h0100 + 16'(i), 32'hA000_0000 + 32'(i), 4'hF});
            exp_ack.push_back(0);
            exp_wr.push_back('{16'h0200 + 16'(i), 32'hB000_0000 + 32'(i), 4'h3});
            exp_ack.push_back(1);
        end
        fork
            for (int i = 0; i < 3; i++) wr(0, 16'h0100 + 16'(i), 32'hA000_0000 + 32'(i), 4'hF, 1'b0);
            for (int j = 0; j < 3; j++) wr(1, 16'h0200 + 16'(j), 32'hB000_0000 + 32'(j), 4'h3, 1'b0);
        join

        // Locked ToD sequence on port 1 keeps port 0 out until it ends.
        ds_delay = 2;
        exp_wr.push_back('{16'h0230, 32'h1111_0000, 4'hF}); exp_ack.push_back(1);
        exp_wr.push_back('{16'h0234, 32'h2222_0000, 4'hF}); exp_ack.push_back(1);
        exp_wr.push_back('{16'h0238, 32'h0000_3333, 4'h3}); exp_ack.push_back(1);
        exp_wr.push_back('{16'h0240, 32'hCAFE_F00D, 4'hF}); exp_ack.push_back(0);
        @(posedge clk); #1;
        fork
            begin
                wr(1, 16'h0230, 32'h1111_0000, 4'hF, 1'b1);
                wr(1, 16'h0234, 32'h2222_0000, 4'hF, 1'b1);
                wr(1, 16'h0238, 32'h0000_3333, 4'h3, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                wr(0, 16'h0240, 32'hCAFE_F00D, 4'hF, 1'b0);
            end
        join

        // Reset two cycles into BUSY: write dropped, then re-granted.
        ds_delay = 10;
        exp_wr.push_back('{16'h0300, 32'h55AA_55AA, 4'hF});
        exp_wr.push_back('{16'h0300, 32'h55AA_55AA, 4'hF});
        exp_ack.push_back(0);
        @(posedge clk); #1;
        fork
            wr(0, 16'h0300, 32'h55AA_55AA, 4'hF, 1'b0);
            begin
                wait_men(ok);
                @(posedge clk); #1;
                rst = 1'b1;
                @(negedge clk);
                chk("rst_wait_held", reg_wr_wait_0, 1);
                @(posedge clk); #1;
                rst = 1'b0;
                ds_delay = 2;
                chk("rst_drops_men", m_reg_wr_en, 0);
                chk("rst_no_ack", reg_wr_ack_0, 0);
            end
        join

        // Downstream never acks.
        ds_enable = 1'b0;
        exp_wr.push_back('{16'h0400, 32'hDEAD_BEEF, 4'h5});
        exp_ack.push_back(0);
        @(posedge clk); #1;
        fork
            wr(0, 16'h0400, 32'hDEAD_BEEF, 4'h5, 1'b0);
            begin
                wait_men(ok);
`ifdef PTP_REG_WR_ARB_TIMEOUT_EN
                repeat (10) @(negedge clk);
                chk("tmo_pulse_cycle", tmo_cyc - men_rise_cyc, 8);
                chk("tmo_ack_cycle", last_ack_cyc - men_rise_cyc, 8);
                chk("tmo_men_dropped", m_reg_wr_en, 0);
`else
                repeat (20) @(negedge clk);
                chk("pend_men", m_reg_wr_en, 1);
                chk("pend_wait", reg_wr_wait_0, 1);
                chk("pend_no_ack", last_ack_cyc < men_rise_cyc, 1);
                ds_enable = 1'b1;
`endif
            end
        join
        ds_enable = 1'b1;
        repeat (4) @(negedge clk);

`ifdef PTP_REG_WR_ARB_TIMEOUT_EN
        chk("tmo_count", tmo_seen, 1);
`else
        chk("tmo_count", tmo_seen, 0);
`endif
        chk("exp_wr_left", exp_wr.size(), 0);
        chk("exp_ack_left", exp_ack.size(), 0);
        chk("idle_at_end", m_reg_wr_en, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
